// File: rtl/addr_reg_fix_if.sv
// Operation/status bundle between the control unit (master) and one address register (slave).
interface addr_reg_fix_if #(
  parameter int ADDR_W = 16,
  parameter int PAGE_W = 8
);
  localparam int HIGH_W = ADDR_W - PAGE_W;

  logic              load_l;
  logic              load_h;
  logic [PAGE_W-1:0] l_in;
  logic [HIGH_W-1:0] h_in;
  logic              inc;
  logic              dec;
  logic              add_en;
  logic [PAGE_W-1:0] offset;
  logic              offset_signed;
  logic              h_inc;
  logic              h_dec;
  logic [PAGE_W-1:0] addr_l;
  logic [HIGH_W-1:0] addr_h;
  logic [ADDR_W-1:0] addr;
  logic              page_cross;
  logic              cross_dir;
  logic              fix_busy;

  modport master (
    output load_l, load_h, l_in, h_in, inc, dec, add_en, offset, offset_signed, h_inc, h_dec,
    input  addr_l, addr_h, addr, page_cross, cross_dir, fix_busy
  );

  modport slave (
    input  load_l, load_h, l_in, h_in, inc, dec, add_en, offset, offset_signed, h_inc, h_dec,
    output addr_l, addr_h, addr, page_cross, cross_dir, fix_busy
  );
endinterface

// File: rtl/addr_reg_fix.sv
// Paged address/pointer register (PC/D/T) with offset add, page-cross detection
// and an optional one-cycle automatic high-field fix-up.
module addr_reg_fix #(
  parameter int                ADDR_W    = 16,
  parameter int                PAGE_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VAL = '0,
  parameter int                AUTO_FIX  = 1
) (
  input logic          clk,
  input logic          rst_n,
  addr_reg_fix_if.slave bus
);
  localparam int HIGH_W = ADDR_W - PAGE_W;

  typedef enum logic {IDLE, FIX} state_e;

  state_e            state_q, state_d;
  logic [HIGH_W-1:0] h_q, h_d;
  logic [PAGE_W-1:0] l_q, l_d;
  logic              pc_q, pc_d;
  logic              dir_q, dir_d;

  logic [PAGE_W+1:0] off_ext;
  logic [PAGE_W+1:0] sum;
  logic              up_cross;
  logic              dn_cross;

  // Two guard bits: bit PAGE_W flags overflow, bit PAGE_W+1 is the sign (underflow).
  assign off_ext  = bus.offset_signed ? {{2{bus.offset[PAGE_W-1]}}, bus.offset}
                                      : {2'b00, bus.offset};
  assign sum      = {2'b00, l_q} + off_ext;
  assign up_cross = ~sum[PAGE_W+1] & sum[PAGE_W];
  assign dn_cross = sum[PAGE_W+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= RESET_VAL[ADDR_W-1:PAGE_W];
      l_q     <= RESET_VAL[PAGE_W-1:0];
      pc_q    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      pc_q    <= pc_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    pc_d    = pc_q;
    dir_d   = dir_q;
    case (state_q)
      FIX: begin
        // Operation inputs are deliberately ignored here, not queued.
        h_d     = dir_q ? h_q - HIGH_W'(1) : h_q + HIGH_W'(1);
        pc_d    = 1'b0;
        dir_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        if (bus.add_en) begin
          l_d   = sum[PAGE_W-1:0];
          pc_d  = up_cross | dn_cross;
          dir_d = dn_cross;
          if ((AUTO_FIX != 0) && (up_cross || dn_cross)) begin
            state_d = FIX;
          end
        end else if (bus.inc) begin
          {h_d, l_d} = {h_q, l_q} + ADDR_W'(1);
          pc_d       = 1'b0;
          dir_d      = 1'b0;
        end else if (bus.dec) begin
          {h_d, l_d} = {h_q, l_q} - ADDR_W'(1);
          pc_d       = 1'b0;
          dir_d      = 1'b0;
        end else if (bus.h_inc) begin
          h_d   = h_q + HIGH_W'(1);
          pc_d  = 1'b0;
          dir_d = 1'b0;
        end else if (bus.h_dec) begin
          h_d   = h_q - HIGH_W'(1);
          pc_d  = 1'b0;
          dir_d = 1'b0;
        end else if (bus.load_l || bus.load_h) begin
          if (bus.load_l) l_d = bus.l_in;
          if (bus.load_h) h_d = bus.h_in;
          pc_d  = 1'b0;
          dir_d = 1'b0;
        end
      end
    endcase
  end

  assign bus.addr_l     = l_q;
  assign bus.addr_h     = h_q;
  assign bus.addr       = {h_q, l_q};
  assign bus.page_cross = pc_q;
  assign bus.cross_dir  = dir_q;
  assign bus.fix_busy   = (state_q == FIX);
endmodule

// File: tb/tb_addr_reg_fix.sv
// Three builds share one stimulus stream: default, RESET_VAL=FFFC, AUTO_FIX=0.
// Expectations are queued with the stimulus and checked one clock later.
module tb_addr_reg_fix;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       load_l, load_h, inc, dec, add_en, offset_signed, h_inc, h_dec;
  logic [7:0] l_in, h_in, offset;

  addr_reg_fix_if #(.ADDR_W(16), .PAGE_W(8)) bus [3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_drive
      assign bus[gi].load_l        = load_l;
      assign bus[gi].load_h        = load_h;
      assign bus[gi].l_in          = l_in;
      assign bus[gi].h_in          = h_in;
      assign bus[gi].inc           = inc;
      assign bus[gi].dec           = dec;
      assign bus[gi].add_en        = add_en;
      assign bus[gi].offset        = offset;
      assign bus[gi].offset_signed = offset_signed;
      assign bus[gi].h_inc         = h_inc;
      assign bus[gi].h_dec         = h_dec;
    end
  endgenerate

  addr_reg_fix #(.ADDR_W(16), .PAGE_W(8), .RESET_VAL(16'h0000), .AUTO_FIX(1)) u_dflt (
    .clk(clk), .rst_n(rst_n), .bus(bus[0]));
  addr_reg_fix #(.ADDR_W(16), .PAGE_W(8), .RESET_VAL(16'hFFFC), .AUTO_FIX(1)) u_rv (
    .clk(clk), .rst_n(rst_n), .bus(bus[1]));
  addr_reg_fix #(.ADDR_W(16), .PAGE_W(8), .RESET_VAL(16'h0000), .AUTO_FIX(0)) u_nf (
    .clk(clk), .rst_n(rst_n), .bus(bus[2]));

  typedef struct {
    int          which;
    logic [18:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic logic [18:0] obs(input int which);
    case (which)
      0:       obs = {bus[0].addr, bus[0].page_cross, bus[0].cross_dir, bus[0].fix_busy};
      1:       obs = {bus[1].addr, bus[1].page_cross, bus[1].cross_dir, bus[1].fix_busy};
      default: obs = {bus[2].addr, bus[2].page_cross, bus[2].cross_dir, bus[2].fix_busy};
    endcase
  endfunction

  task automatic push(input int w, input logic [15:0] a, input logic pc, input logic dir,
                      input logic busy, input string nm);
    sb_t e;
    e.which = w;
    e.exp   = {a, pc, dir, busy};
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  task automatic ops_idle();
    rst_n = 1'b1; load_l = 1'b0; load_h = 1'b0; inc = 1'b0; dec = 1'b0;
    add_en = 1'b0; offset_signed = 1'b0; h_inc = 1'b0; h_dec = 1'b0;
    l_in = 8'h00; h_in = 8'h00; offset = 8'h00;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] l);
    load_l = 1'b1; load_h = 1'b1; h_in = h; l_in = l;
  endtask

  task automatic do_add(input logic [7:0] off, input logic sgn);
    add_en = 1'b1; offset = off; offset_signed = sgn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 2; s++) begin
      ops_idle();
      rst_n = 1'b0;
      if (s == 1) inc = 1'b1;
      push(0, 16'h0000, 0, 0, 0, "reset_dflt");
      push(1, 16'hFFFC, 0, 0, 0, "reset_rv");
      push(2, 16'h0000, 0, 0, 0, "reset_nf");
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_add_no_cross();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 3; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'h12, 8'hF0); push(0, 16'h12F0, 0, 0, 0, "nc_load"); push(2, 16'h12F0, 0, 0, 0, "nc_load"); end
        1: begin do_add(8'h0F, 1'b0); push(0, 16'h12FF, 0, 0, 0, "nc_add"); push(2, 16'h12FF, 0, 0, 0, "nc_add"); end
        default: push(0, 16'h12FF, 0, 0, 0, "nc_hold");
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_add_up_cross();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 4; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'h12, 8'hF0); push(0, 16'h12F0, 0, 0, 0, "up_load"); end
        1: begin do_add(8'h20, 1'b0); push(0, 16'h1210, 1, 0, 1, "up_add"); push(2, 16'h1210, 1, 0, 0, "up_add_nf"); end
        2: begin push(0, 16'h1310, 0, 0, 0, "up_fix"); push(2, 16'h1210, 1, 0, 0, "up_hold_nf"); end
        default: push(0, 16'h1310, 0, 0, 0, "up_idle");
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_signed_down();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 5; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'h12, 8'h05); push(0, 16'h1205, 0, 0, 0, "dn_load"); end
        1: begin do_add(8'hF0, 1'b1); push(0, 16'h12F5, 1, 1, 1, "dn_add"); push(2, 16'h12F5, 1, 1, 0, "dn_add_nf"); end
        2: begin inc = 1'b1; push(0, 16'h11F5, 0, 0, 0, "dn_fix_inc_ignored"); push(2, 16'h12F6, 0, 0, 0, "dn_inc_nf"); end
        3: begin do_add(8'hF0, 1'b0); push(0, 16'h11E5, 1, 0, 1, "uns_F0_add"); end
        default: push(0, 16'h12E5, 0, 0, 0, "uns_F0_fix");
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_wrap();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 7; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'hFF, 8'hFF); push(0, 16'hFFFF, 0, 0, 0, "wr_load"); push(2, 16'hFFFF, 0, 0, 0, "wr_load"); end
        1: begin inc = 1'b1; push(0, 16'h0000, 0, 0, 0, "wr_inc"); push(2, 16'h0000, 0, 0, 0, "wr_inc"); end
        2: begin dec = 1'b1; push(0, 16'hFFFF, 0, 0, 0, "wr_dec"); push(2, 16'hFFFF, 0, 0, 0, "wr_dec"); end
        3: begin do_load(8'h00, 8'h34); push(0, 16'h0034, 0, 0, 0, "wr_load2"); end
        4: begin h_dec = 1'b1; push(0, 16'hFF34, 0, 0, 0, "wr_h_dec"); push(2, 16'hFF34, 0, 0, 0, "wr_h_dec"); end
        5: begin h_inc = 1'b1; push(0, 16'h0034, 0, 0, 0, "wr_h_inc"); end
        default: begin load_l = 1'b1; l_in = 8'hAB; h_in = 8'h77; push(0, 16'h00AB, 0, 0, 0, "wr_load_l_only"); end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_priority();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 7; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'h10, 8'h00); push(0, 16'h1000, 0, 0, 0, "pr_load"); end
        1: begin do_add(8'h05, 1'b0); inc = 1'b1; dec = 1'b1; h_inc = 1'b1; do_load(8'h55, 8'h55);
                 push(0, 16'h1005, 0, 0, 0, "pr_add_wins"); end
        2: begin inc = 1'b1; dec = 1'b1; h_inc = 1'b1; push(0, 16'h1006, 0, 0, 0, "pr_inc_wins"); end
        3: begin dec = 1'b1; h_inc = 1'b1; h_dec = 1'b1; push(0, 16'h1005, 0, 0, 0, "pr_dec_wins"); end
        4: begin h_inc = 1'b1; h_dec = 1'b1; do_load(8'h55, 8'h55); push(0, 16'h1105, 0, 0, 0, "pr_h_inc_wins"); end
        5: begin h_dec = 1'b1; do_load(8'h55, 8'h55); push(0, 16'h1005, 0, 0, 0, "pr_h_dec_wins"); end
        default: begin load_h = 1'b1; h_in = 8'h3C; l_in = 8'h99; push(0, 16'h3C05, 0, 0, 0, "pr_load_h_only"); end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_reset_mid_fix();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 4; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'h12, 8'hF0); push(0, 16'h12F0, 0, 0, 0, "rf_load"); push(1, 16'h12F0, 0, 0, 0, "rf_load"); end
        1: begin do_add(8'h20, 1'b0); push(0, 16'h1210, 1, 0, 1, "rf_add"); push(1, 16'h1210, 1, 0, 1, "rf_add"); end
        2: begin rst_n = 1'b0; push(0, 16'h0000, 0, 0, 0, "rf_reset"); push(1, 16'hFFFC, 0, 0, 0, "rf_reset");
                 push(2, 16'h0000, 0, 0, 0, "rf_reset"); end
        default: begin push(0, 16'h0000, 0, 0, 0, "rf_after"); push(1, 16'hFFFC, 0, 0, 0, "rf_after"); end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_no_autofix();
    sb_t e; logic [18:0] got;
    for (int s = 0; s < 5; s++) begin
      ops_idle();
      case (s)
        0: begin do_load(8'h12, 8'hF0); push(2, 16'h12F0, 0, 0, 0, "nf_load"); end
        1: begin do_add(8'h20, 1'b0); push(2, 16'h1210, 1, 0, 0, "nf_add"); end
        2: push(2, 16'h1210, 1, 0, 0, "nf_hold1");
        3: push(2, 16'h1210, 1, 0, 0, "nf_hold2");
        default: begin h_inc = 1'b1; push(2, 16'h1310, 0, 0, 0, "nf_h_inc"); push(0, 16'h1410, 0, 0, 0, "af_h_inc"); end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = obs(e.which); n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d: addr/pc/dir/busy got %h/%b/%b/%b required %h/%b/%b/%b", e.name, e.which,
                   got[18:3], got[2], got[1], got[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
        end else $display("ok   %s dut%0d: addr=%h pc=%b dir=%b busy=%b", e.name, e.which, got[18:3], got[2], got[1], got[0]);
      end
    end
  endtask

  initial begin
    ops_idle();
    rst_n = 1'b0;
    test_reset();
    test_add_no_cross();
    test_add_up_cross();
    test_signed_down();
    test_wrap();
    test_priority();
    test_reset_mid_fix();
    test_no_autofix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
